iic_slave_regs: RTL

I2C target (slave) with an on-chip 8-bit register file. It sits on the same two-wire bus our `Done`-signalling I2C init master drives, and it answers at 7-bit address 0x76, the same transaction format the master uses. Typical uses are in-FPGA loopback verification of the init sequence and exposing configuration registers to an external I2C host. Supports single and burst writes, register-pointer reads with auto-increment, and repeated START.

---
 rtl/iic_slave_regs.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/iic_slave_regs.sv
// iic_slave_regs: I2C target at SLAVE_ADDR fronting an 8-bit register file with an auto-incrementing pointer.
module iic_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h76,
    parameter int         REG_ADDR_W  = 6,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  SCL_in,
    input  logic                  SDA_in,
    output logic                  SDA_oe,
    output logic                  Reg_wr,
    output logic [REG_ADDR_W-1:0] Reg_addr,
    output logic [7:0]            Reg_wdata,
    input  logic [REG_ADDR_W-1:0] Rd_addr,
    output logic [7:0]            Rd_data,
    output logic                  Busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;
    localparam logic [REG_ADDR_W-1:0] PTR_ONE = 1;
    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl, sda, scl_d, sda_d, rise, fall, start, stop;
    logic [3:0]             cnt, cnt_n;
    logic [7:0]             sh, sh_n, byte_in, rd_byte, wdata_n;
    logic [REG_ADDR_W-1:0]  ptr, ptr_n, addr_n;
    logic                   oe_n, pend, pend_n;
    logic [7:0]             mem [1 << REG_ADDR_W];

    assign scl     = scl_sync[SYNC_STAGES-1];
    assign sda     = sda_sync[SYNC_STAGES-1];
    assign rise    = scl & ~scl_d;
    assign fall    = ~scl & scl_d;
    assign start   = scl & scl_d & sda_d & ~sda;
    assign stop    = scl & scl_d & ~sda_d & sda;
    assign byte_in = {sh[6:0], sda};
    assign rd_byte = mem[ptr];
    assign Rd_data = mem[Rd_addr];
    assign Busy    = (state != IDLE) && (state != IGNORE);

    // Synchronizers reset to the idle-bus level so reset release cannot fake a START
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_in};
            scl_d    <= scl;
            sda_d    <= sda;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            ptr       <= '0;
            SDA_oe    <= 1'b0;
            pend      <= 1'b0;
            Reg_wr    <= 1'b0;
            Reg_addr  <= '0;
            Reg_wdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            ptr       <= ptr_n;
            SDA_oe    <= oe_n;
            pend      <= pend_n;
            Reg_wr    <= pend;
            Reg_addr  <= addr_n;
            Reg_wdata <= wdata_n;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < (1 << REG_ADDR_W); i++) mem[i] <= '0;
        end else if (Reg_wr) begin
            mem[Reg_addr] <= Reg_wdata;
        end
    end

    // ACK states: first SCL fall drives the ACK (SDA_oe=0 -> 1), the second releases it and moves on
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        ptr_n   = ptr;
        oe_n    = SDA_oe;
        pend_n  = 1'b0;
        addr_n  = Reg_addr;
        wdata_n = Reg_wdata;
        if (start) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ADDR, REG, WDATA: if (rise) begin
                    sh_n  = byte_in;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        state_n = state == ADDR ? ADDR_ACK : state == REG ? REG_ACK : WDATA_ACK;
                        if (state == REG) ptr_n = byte_in[REG_ADDR_W-1:0];
                        if (state == WDATA) begin
                            pend_n  = 1'b1;
                            addr_n  = ptr;
                            wdata_n = byte_in;
                            ptr_n   = ptr + PTR_ONE;
                        end
                    end
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: if (fall) begin
                    if (!SDA_oe) begin
                        if (state == ADDR_ACK && sh[7:1] != SLAVE_ADDR) state_n = IGNORE;
                        else oe_n = 1'b1;
                    end else begin
                        oe_n  = 1'b0;
                        cnt_n = '0;
                        if (state == ADDR_ACK && sh[0]) begin
                            state_n = RDATA;
                            sh_n    = rd_byte;
                            oe_n    = ~rd_byte[7];
                        end else begin
                            state_n = state == ADDR_ACK ? REG : WDATA;
                        end
                    end
                end
                RDATA: if (rise) begin
                    cnt_n = cnt + 4'd1;
                end else if (fall) begin
                    if (cnt == 4'd8) begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = RDATA_ACK;
                    end else begin
                        oe_n = ~sh[6];
                        sh_n = {sh[6:0], 1'b0};
                    end
                end
                RDATA_ACK: if (rise) begin
                    if (sda) begin
                        state_n = IGNORE;
                    end else begin
                        cnt_n = 4'd1;
                        ptr_n = ptr + PTR_ONE;
                    end
                end else if (fall && cnt == 4'd1) begin
                    state_n = RDATA;
                    cnt_n   = '0;
                    sh_n    = rd_byte;
                    oe_n    = ~rd_byte[7];
                end
                default: ;
            endcase
        end
    end
endmodule
